// File: rtl/nos_dac_transmitter.sv
// NOS DAC serial transmitter: drives bit clock, latch enable and the
// simultaneous left/right data lines for one stereo sample per handshake.
// The top N bits of each MSB-aligned sample are shifted out MSB-first, then
// latch enable is pulsed and the block returns to idle.
// Word-length codes assume MAX_BITS >= 24.
module nos_dac_transmitter #(
  parameter int unsigned MAX_BITS  = 24,
  parameter int unsigned BCK_DIV   = 2,
  parameter int unsigned LE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          bits_sel,
  input  logic                mute,
  input  logic [MAX_BITS-1:0] sample_l,
  input  logic [MAX_BITS-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                dac_bck,
  output logic                dac_le,
  output logic                dac_data_l,
  output logic                dac_data_r,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned BIT_W = $clog2(MAX_BITS + 1);
  localparam int unsigned PH_W  = $clog2(BCK_DIV + 1);
  localparam int unsigned LE_W  = $clog2(LE_CYCLES + 1);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BCK_DIV - 1);
  localparam logic [LE_W-1:0] LE_LAST = LE_W'(LE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } state_e;

  state_e              state_q, state_d;
  logic [BIT_W-1:0]    nbits_q, nbits_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]     ph_cnt_q, ph_cnt_d;
  logic [LE_W-1:0]     le_cnt_q, le_cnt_d;
  logic [MAX_BITS-1:0] shift_l_q, shift_l_d;
  logic [MAX_BITS-1:0] shift_r_q, shift_r_d;
  logic                bck_q, bck_d;
  logic                le_q, le_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

  // Map the word-length code to the number of transmitted bits.
  function automatic logic [BIT_W-1:0] word_len(input logic [1:0] sel);
    case (sel)
      2'b00:   word_len = BIT_W'(24);
      2'b01:   word_len = BIT_W'(20);
      2'b10:   word_len = BIT_W'(18);
      default: word_len = BIT_W'(16);
    endcase
  endfunction

  assign accept = sample_valid && ready_q;

  // Next-state and next-output logic for the IDLE/SHIFT/LATCH sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d   = state_q;
    nbits_d   = nbits_q;
    bit_cnt_d = bit_cnt_q;
    ph_cnt_d  = ph_cnt_q;
    le_cnt_d  = le_cnt_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    bck_d     = bck_q;
    le_d      = le_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          nbits_d   = word_len(bits_sel);
          shift_l_d = mute ? '0 : sample_l;
          shift_r_d = mute ? '0 : sample_r;
          bit_cnt_d = '0;
          ph_cnt_d  = '0;
          bck_d     = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (ph_cnt_q != PH_LAST) begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end else begin
          ph_cnt_d = '0;
          if (!bck_q) begin
            bck_d = 1'b1;
          end else begin
            // End of a bit: bck falls and the data lines advance together.
            bck_d = 1'b0;
            if (bit_cnt_q == nbits_q - BIT_W'(1)) begin
              state_d   = ST_LATCH;
              shift_l_d = '0;
              shift_r_d = '0;
              le_d      = 1'b1;
              le_cnt_d  = '0;
              done_d    = (LE_LAST == '0);
            end else begin
              shift_l_d = {shift_l_q[MAX_BITS-2:0], 1'b0};
              shift_r_d = {shift_r_q[MAX_BITS-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
      end

      ST_LATCH: begin
        if (le_cnt_q == LE_LAST) begin
          state_d = ST_IDLE;
          le_d    = 1'b0;
        end else begin
          le_cnt_d = le_cnt_q + LE_W'(1);
          done_d   = (le_cnt_q + LE_W'(1) == LE_LAST);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bck_d     = 1'b0;
        le_d      = 1'b0;
        shift_l_d = '0;
        shift_r_d = '0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, counter, shift and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= ST_IDLE;
      nbits_q   <= '0;
      bit_cnt_q <= '0;
      ph_cnt_q  <= '0;
      le_cnt_q  <= '0;
      // NOTE: the shift registers are reset because their MSBs drive the
      // data pins directly and must read 0 out of reset.
      shift_l_q <= '0;
      shift_r_q <= '0;
      bck_q     <= 1'b0;
      le_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nbits_q   <= nbits_d;
      bit_cnt_q <= bit_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      le_cnt_q  <= le_cnt_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      bck_q     <= bck_d;
      le_q      <= le_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sample_ready = ready_q;
  assign dac_bck      = bck_q;
  assign dac_le       = le_q;
  assign dac_data_l   = shift_l_q[MAX_BITS-1];
  assign dac_data_r   = shift_r_q[MAX_BITS-1];
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_nos_dac_transmitter.sv
// Self-checking bench for nos_dac_transmitter: a passive receiver rebuilds
// each frame from the serial lines and it is compared with words and timing
// computed from the sample, word length and mute setting.
module tb_nos_dac_transmitter;

  localparam int MAXB = 24;
  localparam int B    = 2;
  localparam int LE   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      bits_sel = 2'b00;
  logic            mute = 1'b0;
  logic [MAXB-1:0] sample_l = '0;
  logic [MAXB-1:0] sample_r = '0;
  logic            sample_valid = 1'b0;
  logic            sample_ready;
  logic            dac_bck;
  logic            dac_le;
  logic            dac_data_l;
  logic            dac_data_r;
  logic            busy;
  logic            frame_done;

  nos_dac_transmitter #(
    .MAX_BITS (MAXB),
    .BCK_DIV  (B),
    .LE_CYCLES(LE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bits_sel    (bits_sel),
    .mute        (mute),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .dac_bck     (dac_bck),
    .dac_le      (dac_le),
    .dac_data_l  (dac_data_l),
    .dac_data_r  (dac_data_r),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          n;
    logic [31:0] l;
    logic [31:0] r;
  } exp_t;

  typedef struct {
    int          n;
    logic [31:0] l;
    logic [31:0] r;
    int          le_start;
    int          le_len;
    int          done_cnt;
    int          ready_cyc;
  } rx_t;

  exp_t exp_q[$];
  rx_t  rx_q[$];
  int   acc_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Passive receiver: samples at the falling edge, away from DUT updates.
  rx_t  cur = '{default: 0};
  logic prev_bck = 1'b0;
  logic prev_le  = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      cur = '{default: 0};
    end else begin
      if (sample_valid && sample_ready) acc_q.push_back(cyc);
      if (dac_bck && !prev_bck) begin
        cur.l = {cur.l[30:0], dac_data_l};
        cur.r = {cur.r[30:0], dac_data_r};
        cur.n++;
      end
      if (dac_le && !prev_le) cur.le_start = cyc;
      if (dac_le) cur.le_len++;
      if (frame_done) cur.done_cnt++;
      if (!dac_le && prev_le) begin
        cur.ready_cyc = sample_ready ? cyc : -1;
        rx_q.push_back(cur);
        cur = '{default: 0};
      end
    end
    prev_bck = dac_bck;
    prev_le  = dac_le;
  end

  // Stimulus and checks run just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [23:0] l, input logic [23:0] r,
                                 input logic [1:0] sel, input logic mu);
    exp_t e;
    case (sel)
      2'b00:   e.n = 24;
      2'b01:   e.n = 20;
      2'b10:   e.n = 18;
      default: e.n = 16;
    endcase
    e.l = mu ? 32'd0 : 32'(l) >> (24 - e.n);
    e.r = mu ? 32'd0 : 32'(r) >> (24 - e.n);
    return e;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!sample_ready && w < 1000) begin
      step();
      w++;
    end
    if (!sample_ready) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r,
                      input logic [1:0] sel, input logic mu, input bit record);
    wait_ready();
    sample_l     = l;
    sample_r     = r;
    bits_sel     = sel;
    mute         = mu;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    if (record) exp_q.push_back(model(l, r, sel, mu));
  endtask

  task automatic wait_frame(input string tag, output int acc);
    rx_t  rf;
    exp_t e;
    int   w = 0;
    acc = 0;
    while (rx_q.size() == 0 && w < 1000) begin
      step();
      w++;
    end
    if (rx_q.size() == 0 || exp_q.size() == 0 || acc_q.size() == 0) begin
      check({tag, "_frame_timeout"}, 64'd0, 64'd1);
      return;
    end
    rf  = rx_q.pop_front();
    e   = exp_q.pop_front();
    acc = acc_q.pop_front();
    check({tag, "_bits"},     64'(rf.n), 64'(e.n));
    check({tag, "_left"},     64'(rf.l), 64'(e.l));
    check({tag, "_right"},    64'(rf.r), 64'(e.r));
    check({tag, "_le_len"},   64'(rf.le_len), 64'(LE));
    check({tag, "_le_start"}, 64'(rf.le_start - acc), 64'(1 + 2 * B * e.n));
    check({tag, "_ready_ret"}, 64'(rf.ready_cyc - acc), 64'(1 + 2 * B * e.n + LE));
    check({tag, "_done_cnt"}, 64'(rf.done_cnt), 64'd1);
  endtask

  initial begin
    int acc;
    int accs[4];
    logic [23:0] rl[4];
    logic [23:0] rr[4];

    // Reset values.
    repeat (3) step();
    check("rst_ready", 64'(sample_ready), 64'd0);
    check("rst_outs", 64'({dac_bck, dac_le, dac_data_l, dac_data_r, busy, frame_done}), 64'd0);
    reset = 1'b0;
    step();
    check("post_rst_ready", 64'(sample_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);

    // Full 24-bit frame.
    send(24'hA5C3F0, 24'h5A3C0F, 2'b00, 1'b0, 1'b1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready_low", 64'(sample_ready), 64'd0);
    wait_frame("t1", acc);

    // 16-bit frame.
    send(24'hA5C3F0, 24'h5A3C0F, 2'b11, 1'b0, 1'b1);
    wait_frame("t2", acc);

    // Valid held high with four random samples queued.
    for (int i = 0; i < 4; i++) begin
      rl[i] = 24'($urandom);
      rr[i] = 24'($urandom);
    end
    bits_sel = 2'b00;
    mute     = 1'b0;
    sample_l = rl[0];
    sample_r = rr[0];
    sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      exp_q.push_back(model(rl[i], rr[i], 2'b00, 1'b0));
      step();
      if (i < 3) begin
        sample_l = rl[i + 1];
        sample_r = rr[i + 1];
      end else begin
        sample_valid = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) wait_frame($sformatf("t3_%0d", i), accs[i]);
    for (int i = 1; i < 4; i++)
      check($sformatf("t3_spacing_%0d", i), 64'(accs[i] - accs[i - 1]), 64'd101);

    // Muted frame.
    send(24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b1, 1'b1);
    wait_frame("t4", acc);

    // Reset mid-frame.
    send(24'hFFFFFF, 24'hFFFFFF, 2'b00, 1'b0, 1'b0);
    repeat (30) step();
    check("t5_mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    check("t5_rst_outs", 64'({dac_bck, dac_le, dac_data_l, dac_data_r, busy, frame_done}), 64'd0);
    check("t5_rst_ready", 64'(sample_ready), 64'd0);
    repeat (2) step();
    reset = 1'b0;
    step();
    check("t5_ready", 64'(sample_ready), 64'd1);
    check("t5_no_le", 64'(rx_q.size()), 64'd0);
    if (acc_q.size() > 0) void'(acc_q.pop_back());
    send(24'h123456, 24'hFEDCBA, 2'b01, 1'b0, 1'b1);
    wait_frame("t5_after", acc);

    // bits_sel and mute changed mid-frame only affect the next accept.
    send(24'hC0FFEE, 24'h0BADF0, 2'b00, 1'b0, 1'b1);
    repeat (10) step();
    bits_sel = 2'b10;
    mute     = 1'b1;
    wait_frame("t6_cur", acc);
    send(24'hC0FFEE, 24'h0BADF0, 2'b10, 1'b0, 1'b1);
    wait_frame("t6_next", acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nos_dac_transmitter.md
Name: nos_dac_transmitter

Overview:
Synthesizable transmitter for the NOS DAC serial interface: bit clock, latch enable, and simultaneous left and right data lines. It is the driving end of the link that nos_dac_receiver models in the top-level bench. It accepts one stereo sample per handshake from the upstream I2S-to-parallel path inside snos and shifts out the top N bits of each channel MSB-first. It then pulses latch enable and returns to idle.

Parameters:
MAX_BITS, 24, input sample width; samples are MSB-aligned.
BCK_DIV, 2, clk cycles per bck half-period (>=1).
LE_CYCLES, 4, clk cycles that le is held high after the last bit (>=1).

Ports:
clk  in  1  logic clock
reset  in  1  synchronous reset, active-high
bits_sel  in  2  output word length: 00=24, 01=20, 10=18, 11=16; sampled at accept only
mute  in  1  1 = load zeros instead of the samples; sampled at accept only
sample_l  in  MAX_BITS  left sample, MSB-aligned
sample_r  in  MAX_BITS  right sample, MSB-aligned
sample_valid  in  1  upstream sample available
sample_ready  out  1  transmitter can accept a sample
dac_bck  out  1  DAC bit clock
dac_le  out  1  DAC latch enable
dac_data_l  out  1  left serial data
dac_data_r  out  1  right serial data
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse on the last le-high cycle

Behaviour:
- Reset values:
  - sample_ready = 0 during reset, and 1 on the first cycle after reset is released.
  - All other outputs are 0 during reset.
  - The state goes to IDLE.
- Reset mid-frame: the frame is dropped. On the next clk the outputs return to the reset values with no partial le pulse.
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - sample_ready=1; bck, le and data are all 0.
  - Accept occurs when sample_valid && sample_ready.
  - On accept, capture N (from bits_sel) and load shift_l/shift_r, or zeros if mute=1, then go to SHIFT.
  - The upstream must not change the samples in the accept cycle; only the accept edge matters.
- SHIFT:
  - sample_ready=0.
  - Bit k (k = 0..N-1) is sample[MAX_BITS-1-k].
  - Each bit lasts 2*BCK_DIV cycles: bck low for BCK_DIV cycles, then high for BCK_DIV cycles.
  - Data lines change only on the cycle where bck goes low, so data is stable across the rising edge.
  - The MSB appears on dac_data_l/r in the first SHIFT cycle.
  - The low (MAX_BITS-N) bits are never transmitted.
  - After the high phase of bit N-1: bck goes low, data goes to 0, and the state goes to LATCH.
- LATCH:
  - le=1 for LE_CYCLES cycles; bck and data stay 0.
  - frame_done=1 on the final le cycle.
  - The next cycle is IDLE with le=0 and sample_ready=1.
- Frame timing:
  - accept at cycle t
  - SHIFT covers cycles t+1 .. t+2*BCK_DIV*N
  - le is high for LE_CYCLES cycles
  - IDLE returns at t+1+2*BCK_DIV*N+LE_CYCLES
  - Minimum back-to-back period = 1 + 2*BCK_DIV*N + LE_CYCLES clk cycles (101 at the defaults with N=24).
- Counters:
  - bit counter width = clog2(MAX_BITS+1).
  - bck phase counter width = clog2(BCK_DIV+1).
  - le counter width = clog2(LE_CYCLES+1).
  - All counters reset to 0 at each state entry; no wrap-around inside a frame.
- Changes to bits_sel or mute during SHIFT/LATCH have no effect until the next accept.
- sample_valid held high while busy: no accept; the sample is accepted at the next IDLE cycle.
- All outputs are registered (no combinational paths from inputs to outputs).

Test Plan:
1. Reset, defaults, bits_sel=00, sample_l=24'hA5C3F0, sample_r=24'h5A3C0F, one valid pulse:
   - 24 bck rising edges.
   - Receiver captures L=A5C3F0 and R=5A3C0F.
   - le is high for 4 cycles, starting 97 cycles after accept.
   - frame_done pulses once.
2. bits_sel=11 with the same samples:
   - 16 bck edges.
   - Receiver gets L=16'hA5C3, R=16'h5A3C.
   - The next ready comes 69 cycles after accept.
3. sample_valid held high with 4 random samples queued:
   - Accepts are spaced exactly 101 cycles apart.
   - All 4 pairs are received in order with no extra bck edges between frames.
4. mute=1, sample_l=sample_r=24'hFFFFFF:
   - 24 bck edges with both data lines 0.
   - le pulse still occurs.
5. Reset asserted 30 cycles into SHIFT:
   - The next cycle has bck=le=data=0 and busy=0.
   - No le pulse; sample_ready=1 after release.
   - A following frame transmits correctly.
6. bits_sel changed 00→10 mid-frame:
   - The current frame still uses 24 bits.
   - The next accepted frame has 18 bits.
